// File: rtl/platform_collision_sched_pkg.sv
// ----------------------------------------------------------------------------
// game_pkg
// Shared game constants for the platform collision scheduler:
//   - coordinate width and screen limits
//   - platform_t record and the fixed PLATFORMS table scanned by the scheduler
//   - sched_state_t, the scheduler FSM state type
// ----------------------------------------------------------------------------
package game_pkg;

    localparam int COORD_W      = 10;
    localparam int N_PLAT       = 6;
    localparam int PLAT_IDX_W   = 3;
    localparam int SCREEN_W_MAX = 1023;
    localparam int SCREEN_H_MAX = 767;

    // One platform: left edge xs, surface height yp, horizontal length len.
    typedef struct packed {
        logic [COORD_W-1:0] xs;
        logic [COORD_W-1:0] yp;
        logic [COORD_W-1:0] len;
    } platform_t;

    // P2 and P4 deliberately overlap so a single player box can touch both.
    localparam platform_t PLATFORMS [N_PLAT] = '{
        '{xs: 10'd100, yp: 10'd600, len: 10'd150},
        '{xs: 10'd400, yp: 10'd500, len: 10'd120},
        '{xs: 10'd650, yp: 10'd400, len: 10'd100},
        '{xs: 10'd100, yp: 10'd300, len: 10'd200},
        '{xs: 10'd700, yp: 10'd410, len: 10'd150},
        '{xs: 10'd300, yp: 10'd700, len: 10'd400}
    };

    typedef enum logic [1:0] {
        IDLE,
        LATCH,
        SCAN,
        DONE
    } sched_state_t;

endpackage

// File: rtl/platform_collision_sched_if.sv
// ----------------------------------------------------------------------------
// platform_collision_sched_if
// Request/result bundle between the player movement controllers (master) and
// the collision scheduler (slave).
//   req            per-requester request, held until done or dropped to abort
//   x_in..h_in     packed per-requester player box (CW bits each)
//   gnt, done      per-requester grant (one-hot) and one-cycle completion pulse
//   hit, hit_idx   collision result, valid with done
//   x_out, y_out   coordinates as checked, valid with done
// ----------------------------------------------------------------------------
interface platform_collision_sched_if
    import game_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int CW    = COORD_W
);

    logic [N_REQ-1:0]      req;
    logic [N_REQ*CW-1:0]   x_in;
    logic [N_REQ*CW-1:0]   y_in;
    logic [N_REQ*CW-1:0]   w_in;
    logic [N_REQ*CW-1:0]   h_in;
    logic [N_REQ-1:0]      gnt;
    logic [N_REQ-1:0]      done;
    logic                  hit;
    logic [PLAT_IDX_W-1:0] hit_idx;
    logic [CW-1:0]         x_out;
    logic [CW-1:0]         y_out;

    modport master (
        output req, x_in, y_in, w_in, h_in,
        input  gnt, done, hit, hit_idx, x_out, y_out
    );

    modport slave (
        input  req, x_in, y_in, w_in, h_in,
        output gnt, done, hit, hit_idx, x_out, y_out
    );

endinterface

// File: rtl/platform_collision_sched_plat_hit_cmp.sv
// ----------------------------------------------------------------------------
// plat_hit_cmp
// Combinational test of one player box against one platform.
//   x_i, y_i, w_i, h_i   player box (left, top, width, height)
//   plat_i               platform under test
//   hit_o                box spans the platform surface horizontally and
//                        vertically
// ----------------------------------------------------------------------------
module plat_hit_cmp
    import game_pkg::*;
(
    input  logic [COORD_W-1:0] x_i,
    input  logic [COORD_W-1:0] y_i,
    input  logic [COORD_W-1:0] w_i,
    input  logic [COORD_W-1:0] h_i,
    input  platform_t          plat_i,
    output logic               hit_o
);

    // Every sum is widened by one bit so a box near the screen edge cannot
    // wrap around and produce a false collision.
    assign hit_o = ({1'b0, x_i} <= {1'b0, plat_i.xs} + {1'b0, plat_i.len}) &&
                   ({1'b0, x_i} + {1'b0, w_i} >= {1'b0, plat_i.xs}) &&
                   ({1'b0, y_i} + {1'b0, h_i} >= {1'b0, plat_i.yp}) &&
                   (y_i <= plat_i.yp);

endmodule

// File: rtl/platform_collision_sched.sv
// ----------------------------------------------------------------------------
// platform_collision_sched
// Time-shares a single plat_hit_cmp between N_REQ player movement FSMs.
// A granted request is latched, scanned against game_pkg::PLATFORMS one
// platform per cycle, and answered with a one-cycle done pulse carrying the
// hit flag and the lowest colliding platform index.
//   clk, rst_n   system clock, asynchronous active-low reset
//   bus          platform_collision_sched_if.slave request/result bundle
// Build option COLLISION_SCHED_CLAMP_EN: when defined, the latched box is
// clamped onto the screen before scanning and the clamped x/y are returned.
// ----------------------------------------------------------------------------
module platform_collision_sched
    import game_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int CW    = COORD_W
) (
    input logic clk,
    input logic rst_n,
    platform_collision_sched_if.slave bus
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    sched_state_t          state_q, state_d;
    logic [IDX_W-1:0]      rrPtr_q, rrPtr_d;
    logic [IDX_W-1:0]      grant_q, grant_d;
    logic [IDX_W-1:0]      pick;
    logic [PLAT_IDX_W-1:0] platCnt_q, platCnt_d;
    logic [CW-1:0]         x_q, x_d, y_q, y_d, w_q, w_d, h_q, h_d;
    logic                  hit_q, hit_d;
    logic [PLAT_IDX_W-1:0] hitIdx_q, hitIdx_d;
    logic [CW-1:0]         xSel, ySel, wSel, hSel, xChk, yChk;
    platform_t             curPlat;
    logic                  platHit;

    // Rotating priority: walk from the farthest offset back to rr_ptr so the
    // first requester at or after rr_ptr is the one left in pick.
    always_comb begin
        pick = rrPtr_q;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (bus.req[(int'(rrPtr_q) + i) % N_REQ]) begin
                pick = IDX_W'((int'(rrPtr_q) + i) % N_REQ);
            end
        end
    end

    // Select the granted requester's box and, when clamping is built in,
    // pull it back onto the screen. The low edge is fixed first, then the
    // far edge, so a box wider than the screen ends up flush right.
    always_comb begin
        xSel = bus.x_in[int'(grant_q)*CW +: CW];
        ySel = bus.y_in[int'(grant_q)*CW +: CW];
        wSel = bus.w_in[int'(grant_q)*CW +: CW];
        hSel = bus.h_in[int'(grant_q)*CW +: CW];
`ifdef COLLISION_SCHED_CLAMP_EN
        xChk = (xSel == '0) ? CW'(1) : xSel;
        if ({1'b0, xChk} + {1'b0, wSel} > (CW+1)'(SCREEN_W_MAX)) begin
            xChk = CW'(SCREEN_W_MAX) - wSel;
        end
        yChk = (ySel == '0) ? CW'(1) : ySel;
        if ({1'b0, yChk} + {1'b0, hSel} > (CW+1)'(SCREEN_H_MAX)) begin
            yChk = CW'(SCREEN_H_MAX) - hSel;
        end
`else
        xChk = xSel;
        yChk = ySel;
`endif
    end

    // Feed the shared comparator with the platform addressed by the scan
    // counter; counter values past the table never occur while scanning.
    always_comb begin
        curPlat = '0;
        if (platCnt_q < PLAT_IDX_W'(N_PLAT)) begin
            curPlat = PLATFORMS[platCnt_q];
        end
    end

    plat_hit_cmp u_cmp (
        .x_i    (x_q),
        .y_i    (y_q),
        .w_i    (w_q),
        .h_i    (h_q),
        .plat_i (curPlat),
        .hit_o  (platHit)
    );

    // Scheduler next-state logic. Dropping the granted req during LATCH or
    // SCAN abandons the request without a done pulse and without moving
    // rr_ptr; rr_ptr only advances once a result has been delivered.
    always_comb begin
        state_d   = state_q;
        rrPtr_d   = rrPtr_q;
        grant_d   = grant_q;
        platCnt_d = platCnt_q;
        x_d       = x_q;
        y_d       = y_q;
        w_d       = w_q;
        h_d       = h_q;
        hit_d     = hit_q;
        hitIdx_d  = hitIdx_q;
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    grant_d = pick;
                    state_d = LATCH;
                end
            end
            LATCH: begin
                if (!bus.req[grant_q]) begin
                    state_d = IDLE;
                end else begin
                    x_d       = xChk;
                    y_d       = yChk;
                    w_d       = wSel;
                    h_d       = hSel;
                    hit_d     = 1'b0;
                    hitIdx_d  = '0;
                    platCnt_d = '0;
                    state_d   = SCAN;
                end
            end
            SCAN: begin
                if (!bus.req[grant_q]) begin
                    state_d = IDLE;
                end else begin
                    if (platHit && !hit_q) begin
                        hit_d    = 1'b1;
                        hitIdx_d = platCnt_q;
                    end
                    if (platCnt_q == PLAT_IDX_W'(N_PLAT - 1)) begin
                        state_d = DONE;
                    end else begin
                        platCnt_d = platCnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                rrPtr_d = (int'(grant_q) == N_REQ - 1) ? '0 : grant_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset returns everything to zero so an
    // in-flight scan is discarded immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rrPtr_q   <= '0;
            grant_q   <= '0;
            platCnt_q <= '0;
            x_q       <= '0;
            y_q       <= '0;
            w_q       <= '0;
            h_q       <= '0;
            hit_q     <= 1'b0;
            hitIdx_q  <= '0;
        end else begin
            state_q   <= state_d;
            rrPtr_q   <= rrPtr_d;
            grant_q   <= grant_d;
            platCnt_q <= platCnt_d;
            x_q       <= x_d;
            y_q       <= y_d;
            w_q       <= w_d;
            h_q       <= h_d;
            hit_q     <= hit_d;
            hitIdx_q  <= hitIdx_d;
        end
    end

    // Grant covers LATCH through DONE; done is the DONE cycle alone.
    always_comb begin
        bus.gnt  = '0;
        bus.done = '0;
        if (state_q != IDLE) begin
            bus.gnt[grant_q] = 1'b1;
        end
        if (state_q == DONE) begin
            bus.done[grant_q] = 1'b1;
        end
    end

    assign bus.hit     = hit_q;
    assign bus.hit_idx = hitIdx_q;
    assign bus.x_out   = x_q;
    assign bus.y_out   = y_q;

endmodule

// File: tb/tb_platform_collision_sched.sv
// ----------------------------------------------------------------------------
// tb_platform_collision_sched
// Directed scenarios with hand-computed expectations, followed by randomized
// request/coordinate/reset traffic checked every cycle against a
// transaction-level model of the scheduler.
// ----------------------------------------------------------------------------
module tb_platform_collision_sched;
    import game_pkg::*;

    localparam int N_REQ   = 2;
    localparam int CW      = COORD_W;
    localparam int SERVICE = N_PLAT + 2;
`ifdef COLLISION_SCHED_CLAMP_EN
    localparam int EXP_LOW = 1;
`else
    localparam int EXP_LOW = 0;
`endif

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    int   mBusy;
    int   mGrant;
    int   mRr;
    int   mHit, mIdx, mX, mY;

    platform_collision_sched_if #(.N_REQ(N_REQ), .CW(CW)) bus ();

    platform_collision_sched #(.N_REQ(N_REQ), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record one comparison and report it when it disagrees.
    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Drive one requester's player box.
    task automatic applyStimulus(input int k, input int x, input int y, input int w, input int h);
        bus.x_in[k*CW +: CW] = CW'(x);
        bus.y_in[k*CW +: CW] = CW'(y);
        bus.w_in[k*CW +: CW] = CW'(w);
        bus.h_in[k*CW +: CW] = CW'(h);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Count cycles (current one is 1) until done[k]; flag any other done seen.
    task automatic waitDone(input int k, output int cycles, output int other);
        cycles = 0;
        other  = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cycles++;
            if (bus.done[k]) return;
            if (bus.done != '0) other = 1;
        end
        cycles = -1;
    endtask

    // Screen clamp plus lowest-index scan of the platform table.
    function automatic void modelResult(input int x, input int y, input int w, input int h,
                                        output int hit, output int idx,
                                        output int xo, output int yo);
        int cx, cy;
        cx = x;
        cy = y;
`ifdef COLLISION_SCHED_CLAMP_EN
        if (cx < 1) cx = 1;
        if (cx + w > SCREEN_W_MAX) cx = SCREEN_W_MAX - w;
        if (cy < 1) cy = 1;
        if (cy + h > SCREEN_H_MAX) cy = SCREEN_H_MAX - h;
`endif
        hit = 0;
        idx = 0;
        for (int p = 0; p < N_PLAT; p++) begin
            int xs, yp, len;
            xs  = int'(PLATFORMS[p].xs);
            yp  = int'(PLATFORMS[p].yp);
            len = int'(PLATFORMS[p].len);
            if (hit == 0 && cx <= xs + len && cx + w >= xs && cy + h >= yp && cy <= yp) begin
                hit = 1;
                idx = p;
            end
        end
        xo = cx;
        yo = cy;
    endfunction

    // Transaction model: the server is free (mBusy=0) or mBusy cycles into
    // serving mGrant; service is SERVICE cycles with done on the last one and
    // ends early if the granted req is seen low before that.
    always @(negedge clk) begin
        int expGnt, expDone;
        if (!rst_n) begin
            mBusy = 0;
            mRr   = 0;
            checkOutput("reset_gnt", int'(bus.gnt), 0);
            checkOutput("reset_done", int'(bus.done), 0);
            checkOutput("reset_hit", int'(bus.hit), 0);
            checkOutput("reset_xy", int'(bus.x_out) + int'(bus.y_out) + int'(bus.hit_idx), 0);
        end else begin
            expGnt  = 0;
            expDone = 0;
            if (mBusy == 0) begin
                if (bus.req != '0) begin
                    for (int i = N_REQ - 1; i >= 0; i--) begin
                        if (bus.req[(mRr + i) % N_REQ]) mGrant = (mRr + i) % N_REQ;
                    end
                    mBusy = 1;
                end
            end else begin
                expGnt = 1 << mGrant;
                if (mBusy == SERVICE) begin
                    expDone = expGnt;
                    checkOutput("model_hit", int'(bus.hit), mHit);
                    checkOutput("model_hit_idx", int'(bus.hit_idx), mIdx);
                    checkOutput("model_x_out", int'(bus.x_out), mX);
                    checkOutput("model_y_out", int'(bus.y_out), mY);
                    mRr   = (mGrant + 1) % N_REQ;
                    mBusy = 0;
                end else begin
                    if (mBusy == 1) begin
                        modelResult(int'(bus.x_in[mGrant*CW +: CW]), int'(bus.y_in[mGrant*CW +: CW]),
                                    int'(bus.w_in[mGrant*CW +: CW]), int'(bus.h_in[mGrant*CW +: CW]),
                                    mHit, mIdx, mX, mY);
                    end
                    if (!bus.req[mGrant]) mBusy = 0;
                    else mBusy++;
                end
            end
            checkOutput("model_gnt", int'(bus.gnt), expGnt);
            checkOutput("model_done", int'(bus.done), expDone);
        end
    end

    initial begin
        int c, o;
        vectors     = 0;
        miscompares = 0;
        mBusy       = 0;
        mRr         = 0;
        mGrant      = 0;
        rst_n       = 1'b0;
        bus.req     = '0;
        bus.x_in    = '0;
        bus.y_in    = '0;
        bus.w_in    = '0;
        bus.h_in    = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        nextCycle();

        // 1: P0 hit on requester 0
        applyStimulus(0, 105, 581, 30, 20);
        bus.req = 2'b01;
        waitDone(0, c, o);
        checkOutput("t1_latency", c, 9);
        checkOutput("t1_hit", int'(bus.hit), 1);
        checkOutput("t1_hit_idx", int'(bus.hit_idx), 0);
        checkOutput("t1_x_out", int'(bus.x_out), 105);
        checkOutput("t1_y_out", int'(bus.y_out), 581);
        nextCycle();
        bus.req = '0;
        nextCycle();

        // 2: corner box touching nothing on requester 1
        applyStimulus(1, 0, 0, 32, 32);
        bus.req = 2'b10;
        waitDone(1, c, o);
        checkOutput("t2_latency", c, 9);
        checkOutput("t2_hit", int'(bus.hit), 0);
        checkOutput("t2_hit_idx", int'(bus.hit_idx), 0);
        checkOutput("t2_x_out", int'(bus.x_out), EXP_LOW);
        checkOutput("t2_y_out", int'(bus.y_out), EXP_LOW);
        nextCycle();
        bus.req = '0;
        nextCycle();

        // 3/4: both held, alternate 0,1,0; requester 1 overlaps P2 and P4
        applyStimulus(0, 105, 581, 30, 20);
        applyStimulus(1, 710, 380, 20, 40);
        bus.req = 2'b11;
        waitDone(0, c, o);
        checkOutput("t3_first_latency", c, 9);
        waitDone(1, c, o);
        checkOutput("t3_second_latency", c, 9);
        checkOutput("t4_hit", int'(bus.hit), 1);
        checkOutput("t4_hit_idx", int'(bus.hit_idx), 2);
        waitDone(0, c, o);
        checkOutput("t3_third_latency", c, 9);
        checkOutput("t3_other_done", o, 0);
        nextCycle();
        bus.req = '0;
        nextCycle();

        applyStimulus(0, 710, 380, 20, 40);
        bus.req = 2'b01;
        waitDone(0, c, o);
        checkOutput("t4b_hit_idx", int'(bus.hit_idx), 2);
        checkOutput("t4b_x_out", int'(bus.x_out), 710);
        nextCycle();
        bus.req = '0;
        nextCycle();

        // 5: abort requester 0 at scan cycle 3 with requester 1 pending
        bus.req = 2'b01;
        nextCycle();
        bus.req = 2'b11;
        repeat (4) nextCycle();
        bus.req = 2'b10;
        waitDone(1, c, o);
        checkOutput("t5_latency_after_drop", c, 10);
        checkOutput("t5_no_done0", o, 0);
        checkOutput("t5_hit_idx", int'(bus.hit_idx), 2);
        nextCycle();
        bus.req = '0;
        nextCycle();

        // 6: async reset mid-scan, then a fresh request
        applyStimulus(0, 105, 581, 30, 20);
        bus.req = 2'b01;
        repeat (3) nextCycle();
        checkOutput("t6_gnt_before", int'(bus.gnt), 1);
        checkOutput("t6_hit_before", int'(bus.hit), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("t6_gnt_reset", int'(bus.gnt), 0);
        checkOutput("t6_done_reset", int'(bus.done), 0);
        checkOutput("t6_hit_reset", int'(bus.hit), 0);
        bus.req = '0;
        nextCycle();
        rst_n   = 1'b1;
        bus.req = 2'b01;
        waitDone(0, c, o);
        checkOutput("t6_latency", c, 9);
        nextCycle();
        bus.req = '0;
        nextCycle();

        // Randomized traffic with occasional aborts and async resets
        for (int n = 0; n < 4000; n++) begin
            nextCycle();
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 799) == 0) rst_n = 1'b0;
            for (int k = 0; k < N_REQ; k++) begin
                if ($urandom_range(0, 11) == 0) bus.req[k] = ~bus.req[k];
                if ($urandom_range(0, 3) == 0) begin
                    int rx, ry, rw, rh;
                    rx = int'($urandom_range(0, 1023));
                    ry = int'($urandom_range(0, 767));
                    rw = int'($urandom_range(1, 300));
                    rh = int'($urandom_range(1, 300));
                    if ($urandom_range(0, 7) == 0) rx = 0;
                    if ($urandom_range(0, 7) == 0) ry = 0;
                    applyStimulus(k, rx, ry, rw, rh);
                end
            end
        end
        nextCycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
